// File: rtl/stc_acc_pkg.sv
// Shared definitions for the sparse tensor-core tile accumulator.
// Holds the FSM state type, the default tile depth and the lane-slice index helper.
package stc_acc_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } stc_state_e;

    localparam int K_MAX_DEF = 256;

    // Flat lane index of lane l in PE p, used to locate a lane's slice in packed buses
    function automatic int lane_idx(input int p, input int l, input int n);
        return p * n + l;
    endfunction

endpackage

// File: rtl/stc_accum_tile_lane.sv
// One accumulator lane: base + sign-extended product, gated by the PE enable.
// With STC_ACC_SAT_EN defined the add clamps to the signed DW_ACC range and flags it.
module stc_acc_lane #(
    parameter int DW_IN  = 32,
    parameter int DW_ACC = 32
) (
    input  logic [DW_ACC-1:0] base_i,
    input  logic [DW_IN-1:0]  mult_i,
    input  logic              en_i,
    output logic [DW_ACC-1:0] sum_o,
    output logic              ovf_o
);

    logic [DW_ACC-1:0] ext;

    assign ext = en_i ? DW_ACC'($signed(mult_i)) : '0;

`ifdef STC_ACC_SAT_EN
    logic signed [DW_ACC:0] wide;
    logic                   sat;

    assign wide = $signed({base_i[DW_ACC-1], base_i}) + $signed({ext[DW_ACC-1], ext});

    // A carry into the guard bit that disagrees with the sign bit means the sum left the range
    always_comb begin
        sat   = wide[DW_ACC] ^ wide[DW_ACC-1];
        sum_o = wide[DW_ACC-1:0];
        if (sat) begin
            sum_o = wide[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}} : {1'b0, {(DW_ACC-1){1'b1}}};
        end
        ovf_o = sat;
    end
`else
    assign sum_o = base_i + ext;
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/stc_accum_tile.sv
// Tile accumulator: sums K beats per lane, optionally seeded, with a one-tile output buffer.
// Optional saturation and sticky per-PE overflow are enabled by defining STC_ACC_SAT_EN.
module stc_accum_tile
    import stc_acc_pkg::*;
#(
    parameter int N_PE   = 4,
    parameter int N      = 16,
    parameter int DW_IN  = 32,
    parameter int DW_ACC = 32,
    parameter int K_MAX  = K_MAX_DEF,
    parameter int CW     = $clog2(K_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CW-1:0]            cfg_k,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_PE*N*DW_IN-1:0]  in_mult,
    input  logic [N_PE*N*DW_ACC-1:0] in_psum,
    input  logic [N_PE-1:0]          in_seed,
    input  logic [N_PE-1:0]          in_pe_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_PE*N*DW_ACC-1:0] out_data,
    output logic                     busy,
    output logic [N_PE-1:0]          ovf
);

    localparam int LANES = N_PE * N;

    stc_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           k_lat_q, k_lat_d;
    logic [LANES*DW_ACC-1:0] acc_q, acc_d;
    logic [LANES*DW_ACC-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [N_PE-1:0]         pe_ovf_q, pe_ovf_d;
    logic [N_PE-1:0]         ovf_q, ovf_d;

    logic [LANES*DW_ACC-1:0] sum_w;
    logic [LANES-1:0]        lane_ovf;
    logic [N_PE-1:0]         tile_ovf;
    logic [CW-1:0]           k_eff;
    logic                    first_beat;
    logic                    last_beat;
    logic                    fire;

    assign first_beat = (state_q == ST_IDLE);
    assign k_eff      = (cfg_k == '0) ? CW'(1) : cfg_k;
    assign last_beat  = first_beat ? (k_eff == CW'(1)) : (cnt_q == k_lat_q - CW'(1));
    // Only a tile-completing beat can stall, and only while the buffer holds an unread tile
    assign in_ready   = !(last_beat && out_valid_q && !out_ready);
    assign fire       = in_valid && in_ready;

    for (genvar p = 0; p < N_PE; p++) begin : g_pe
        for (genvar l = 0; l < N; l++) begin : g_lane
            localparam int I = lane_idx(p, l, N);
            logic [DW_ACC-1:0] base;

            assign base = first_beat ? (in_seed[p] ? in_psum[I*DW_ACC +: DW_ACC] : '0)
                                     : acc_q[I*DW_ACC +: DW_ACC];

            stc_acc_lane #(
                .DW_IN  (DW_IN),
                .DW_ACC (DW_ACC)
            ) u_lane (
                .base_i (base),
                .mult_i (in_mult[I*DW_IN +: DW_IN]),
                .en_i   (in_pe_en[p]),
                .sum_o  (sum_w[I*DW_ACC +: DW_ACC]),
                .ovf_o  (lane_ovf[I])
            );
        end
    end

    always_comb begin
        tile_ovf = '0;
        for (int p = 0; p < N_PE; p++) begin
            tile_ovf[p] = (|lane_ovf[p*N +: N]) | (!first_beat && pe_ovf_q[p]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_lat_d     = k_lat_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        pe_ovf_d    = pe_ovf_q;
        ovf_d       = ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (fire) begin
            acc_d    = sum_w;
            pe_ovf_d = tile_ovf;
            if (last_beat) begin
                out_valid_d = 1'b1;
                out_data_d  = sum_w;
                ovf_d       = tile_ovf;
                state_d     = ST_IDLE;
                cnt_d       = '0;
            end else if (first_beat) begin
                state_d = ST_ACC;
                cnt_d   = CW'(1);
                k_lat_d = k_eff;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_lat_q     <= CW'(1);
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pe_ovf_q    <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_lat_q     <= k_lat_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            pe_ovf_q    <= pe_ovf_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stc_accum_tile.sv
// Testbench for stc_accum_tile: directed scenarios plus randomized beats against a lane-level model.
// A second small instance (8-bit lanes) exercises the STC_ACC_SAT_EN boundary.
module tb_stc_accum_tile;

    localparam int NP  = 4;
    localparam int NL  = 4;
    localparam int LN  = NP * NL;
    localparam int DI  = 8;
    localparam int DA  = 12;
    localparam int KM  = 16;
    localparam int CWB = $clog2(KM + 1);

    localparam longint AMAX   = (longint'(1) << (DA - 1)) - 1;
    localparam longint AMIN   = -(longint'(1) << (DA - 1));
    localparam longint ARANGE = longint'(1) << DA;

`ifdef STC_ACC_SAT_EN
    localparam logic [7:0] S_OVF_LANE = 8'h7F;
    localparam logic [1:0] S_OVF_BOTH = 2'b11;
    localparam logic [1:0] S_OVF_PE1  = 2'b10;
`else
    localparam logic [7:0] S_OVF_LANE = 8'h80;
    localparam logic [1:0] S_OVF_BOTH = 2'b00;
    localparam logic [1:0] S_OVF_PE1  = 2'b00;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [CWB-1:0]    cfg_k;
    logic              in_valid, in_ready;
    logic [LN*DI-1:0]  in_mult;
    logic [LN*DA-1:0]  in_psum;
    logic [NP-1:0]     in_seed, in_pe_en, ovf;
    logic              out_valid, out_ready, busy;
    logic [LN*DA-1:0]  out_data;

    logic [2:0]        s_cfg_k;
    logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [31:0]       s_in_mult, s_in_psum, s_out_data;
    logic [1:0]        s_in_seed, s_in_pe_en, s_ovf;

    always #5 clk = ~clk;

    stc_accum_tile #(
        .N_PE(NP), .N(NL), .DW_IN(DI), .DW_ACC(DA), .K_MAX(KM), .CW(CWB)
    ) dut (
        .clk(clk), .reset(reset), .cfg_k(cfg_k), .in_valid(in_valid), .in_ready(in_ready),
        .in_mult(in_mult), .in_psum(in_psum), .in_seed(in_seed), .in_pe_en(in_pe_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .ovf(ovf)
    );

    stc_accum_tile #(
        .N_PE(2), .N(2), .DW_IN(8), .DW_ACC(8), .K_MAX(4), .CW(3)
    ) dut_small (
        .clk(clk), .reset(reset), .cfg_k(s_cfg_k), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_mult(s_in_mult), .in_psum(s_in_psum), .in_seed(s_in_seed), .in_pe_en(s_in_pe_en),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy),
        .ovf(s_ovf)
    );

    typedef struct {
        logic [LN*DA-1:0] data;
        logic [NP-1:0]    ovf;
    } tile_t;

    tile_t       exp_q[$];
    tile_t       mon_t;
    longint      m_acc[LN];
    logic [NP-1:0] m_ovf;
    int          m_cnt = 0;
    int          m_k = 1;
    bit          rand_ready = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          w;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference add: exact integer sum, then clamp or wrap into the signed accumulator range
    function automatic longint acc_add(input longint a, input longint b, output bit o);
        longint r;
        r = a + b;
        o = 1'b0;
`ifdef STC_ACC_SAT_EN
        if (r > AMAX) begin
            r = AMAX;
            o = 1'b1;
        end else if (r < AMIN) begin
            r = AMIN;
            o = 1'b1;
        end
`else
        r = ((r - AMIN) % ARANGE + ARANGE) % ARANGE + AMIN;
`endif
        return r;
    endfunction

    function automatic logic [LN*DI-1:0] fill_mult(input int v);
        logic [LN*DI-1:0] r;
        for (int i = 0; i < LN; i++) r[i*DI +: DI] = DI'(v);
        return r;
    endfunction

    function automatic logic [LN*DA-1:0] fill_acc(input int v);
        logic [LN*DA-1:0] r;
        for (int i = 0; i < LN; i++) r[i*DA +: DA] = DA'(v);
        return r;
    endfunction

    task automatic model_accept();
        bit     o;
        longint b;
        tile_t  t;
        if (m_cnt == 0) begin
            m_k   = (cfg_k == 0) ? 1 : int'(cfg_k);
            m_ovf = '0;
            for (int i = 0; i < LN; i++)
                m_acc[i] = in_seed[i/NL] ? longint'($signed(in_psum[i*DA +: DA])) : 64'sd0;
        end
        for (int i = 0; i < LN; i++) begin
            b = in_pe_en[i/NL] ? longint'($signed(in_mult[i*DI +: DI])) : 64'sd0;
            m_acc[i] = acc_add(m_acc[i], b, o);
            if (o) m_ovf[i/NL] = 1'b1;
        end
        m_cnt++;
        if (m_cnt == m_k) begin
            for (int i = 0; i < LN; i++) t.data[i*DA +: DA] = DA'(m_acc[i]);
            t.ovf = m_ovf;
            exp_q.push_back(t);
            m_cnt = 0;
        end
    endtask

    // Present one beat and hold it until accepted; leaves in_valid high for back-to-back beats
    task automatic applyStimulus(input logic [LN*DI-1:0] mult, input logic [LN*DA-1:0] psum,
                                 input logic [NP-1:0] seed, input logic [NP-1:0] en,
                                 output int waited);
        in_valid = 1'b1;
        in_mult  = mult;
        in_psum  = psum;
        in_seed  = seed;
        in_pe_en = en;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            waited++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("accept_timeout", 256'(in_ready), 256'(1));
        else model_accept();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_reset_values();
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_out_data", 256'(out_data), 256'(0));
        checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_ovf", 256'(ovf), 256'(0));
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", 256'(1), 256'(0));
            end else begin
                mon_t = exp_q.pop_front();
                checkOutput("out_data", 256'(out_data), 256'(mon_t.data));
                checkOutput("out_ovf", 256'(ovf), 256'(mon_t.ovf));
            end
        end
    end

    initial begin
        logic [LN*DA-1:0] exp2;
        reset = 1'b0;
        in_valid = 1'b0; cfg_k = CWB'(1); in_mult = '0; in_psum = '0;
        in_seed = '0; in_pe_en = '1; out_ready = 1'b1;
        s_in_valid = 1'b0; s_cfg_k = 3'd1; s_in_mult = '0; s_in_psum = '0;
        s_in_seed = '0; s_in_pe_en = '1; s_out_ready = 1'b1;
        #12;
        check_reset_values();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Four beats of 1, unseeded
        cfg_k = CWB'(4);
        for (int b = 0; b < 4; b++) applyStimulus(fill_mult(1), '0, '0, '1, w);
        in_valid = 1'b0;
        checkOutput("t1_valid", 256'(out_valid), 256'(1));
        checkOutput("t1_data", 256'(out_data), 256'(fill_acc(4)));
        @(posedge clk);
        #1;
        checkOutput("t1_pulse", 256'(out_valid), 256'(0));

        // Seeded two-beat tile with PE2 disabled on the second beat
        cfg_k = CWB'(2);
        applyStimulus(fill_mult(5), fill_acc(100), '1, '1, w);
        applyStimulus(fill_mult(-3), fill_acc(0), '0, 4'b1011, w);
        in_valid = 1'b0;
        for (int i = 0; i < LN; i++) exp2[i*DA +: DA] = (i / NL == 2) ? DA'(105) : DA'(102);
        checkOutput("t2_data", 256'(out_data), 256'(exp2));
        @(posedge clk);
        #1;

        // Single-beat tiles streaming back to back
        cfg_k = CWB'(1);
        for (int b = 0; b < 8; b++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                          NP'($urandom), NP'($urandom), w);
            checkOutput("t3_ready", 256'(w), 256'(0));
            checkOutput("t3_valid", 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Unread tile blocks only the last beat of the following tile
        out_ready = 1'b0;
        cfg_k = CWB'(1);
        applyStimulus(fill_mult(7), '0, '0, '1, w);
        cfg_k = CWB'(3);
        applyStimulus(fill_mult(1), '0, '0, '1, w);
        checkOutput("t4_beat1", 256'(w), 256'(0));
        applyStimulus(fill_mult(1), '0, '0, '1, w);
        checkOutput("t4_beat2", 256'(w), 256'(0));
        @(negedge clk);
        checkOutput("t4_stall", 256'(in_ready), 256'(0));
        checkOutput("t4_hold", 256'(out_data), 256'(fill_acc(7)));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t4_stall2", 256'(in_ready), 256'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(fill_mult(1), '0, '0, '1, w);
        in_valid = 1'b0;
        checkOutput("t4_release", 256'(w), 256'(0));
        checkOutput("t4_second", 256'(out_data), 256'(fill_acc(3)));
        @(posedge clk);
        #1;

        // Reset in the middle of a tile discards it
        cfg_k = CWB'(4);
        applyStimulus(fill_mult(2), '0, '0, '1, w);
        applyStimulus(fill_mult(2), '0, '0, '1, w);
        in_valid = 1'b0;
        checkOutput("t5_busy", 256'(busy), 256'(1));
        reset = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        #1;
        check_reset_values();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) applyStimulus(fill_mult(2), '0, '0, '1, w);
        in_valid = 1'b0;
        checkOutput("t5_data", 256'(out_data), 256'(fill_acc(8)));
        @(posedge clk);
        #1;

        // Randomized beats, depths, gaps and back-pressure
        rand_ready = 1'b1;
        for (int b = 0; b < 300; b++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            cfg_k = CWB'($urandom_range(0, 6));
            applyStimulus({$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                          NP'($urandom), NP'($urandom), w);
        end
        while (m_cnt != 0)
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, '0, '0, '1, w);
        in_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("drain_empty", 256'(exp_q.size()), 256'(0));

        // Range boundary on an 8-bit accumulator
        s_cfg_k = 3'd1; s_in_pe_en = 2'b11; s_in_mult = {4{8'h01}};
        s_in_seed = 2'b11; s_in_psum = {4{8'h7F}};
        s_in_valid = 1'b1;
        @(negedge clk);
        checkOutput("s_ready", 256'(s_in_ready), 256'(1));
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        checkOutput("s_sat_data", 256'(s_out_data), 256'({4{S_OVF_LANE}}));
        checkOutput("s_sat_ovf", 256'(s_ovf), 256'(S_OVF_BOTH));
        s_in_seed = 2'b10;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        checkOutput("s_mix_data", 256'(s_out_data), 256'({S_OVF_LANE, S_OVF_LANE, 8'h01, 8'h01}));
        checkOutput("s_mix_ovf", 256'(s_ovf), 256'(S_OVF_PE1));
        s_in_seed = 2'b00;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        checkOutput("s_clean_data", 256'(s_out_data), 256'({4{8'h01}}));
        checkOutput("s_clean_ovf", 256'(s_ovf), 256'(0));
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
